entity_move_arbiter: RTL and testbench
======================================

Name: entity_move_arbiter

Overview:
Parametrised successor to the single-player move/interact path. It accepts move requests from N_ENT entities (player plus NPCs), arbitrates them round-robin, and checks each target cell for map bounds, entity occupancy and tile passability. The tile check is one read through the map BRAM port. The block owns all entity positions and feeds them to the renderer and game logic; it runs on the logic clock.

Parameters:
N_ENT, 4, number of entities; index 0 is the player
COORD_W, 4, bits per x/y coordinate
MAP_WIDTH, 16, map columns; legal x is 0..MAP_WIDTH-1
MAP_HEIGHT, 16, map rows; legal y is 0..MAP_HEIGHT-1
ADDR_W, 19, map RAM address width
TILE_W, 16, tile id width
RAM_LAT, 1, map RAM read latency in cycles (>=1)
PASS_MAX, 15, tile ids 0..PASS_MAX are passable; larger ids block
INIT_X, 0, packed N_ENT*COORD_W reset x positions (entity i in slice i)
INIT_Y, 0, packed N_ENT*COORD_W reset y positions

Ports:
clk  in  1  logic clock
sys_rst  in  1  synchronous reset, active-high
move_req  in  N_ENT  one-cycle request pulse per entity
move_dir  in  2*N_ENT  direction per entity (0 up y-1, 1 down y+1, 2 left x-1, 3 right x+1); sampled with move_req
pos_x  out  N_ENT*COORD_W  current x per entity
pos_y  out  N_ENT*COORD_W  current y per entity
ram_addr  out  ADDR_W  map read address, registered
ram_data  in  TILE_W  map read data, valid RAM_LAT cycles after ram_addr changes
done_valid  out  1  one-cycle result pulse
done_id  out  clog2(N_ENT)  entity the result refers to
done_code  out  2  0 moved, 1 out of bounds, 2 entity collision, 3 tile blocked
done_tile  out  TILE_W  tile id read (0 if no read was made)
busy  out  1  high when the FSM is not IDLE

Behaviour:
- Reset (sys_rst=1 at a clk edge, any state): pos = INIT_X/INIT_Y; pending and direction latches cleared; FSM to IDLE; ram_addr=0; done_valid=0, done_id=0, done_code=0, done_tile=0; busy=0. Any in-flight request is discarded without a done pulse.
- Pending latch per entity: move_req[i]=1 sets pending[i] and stores move_dir[i].
  - A repeat request while pending overwrites the direction; latest wins.
  - A request in the same cycle the entity is granted is captured as a new pending request.
- FSM states: IDLE, CHECK, WAIT, DECIDE.
- IDLE: if any pending bit is set, grant the first set bit searching from last_grant+1 (mod N_ENT); last_grant resets to N_ENT-1. Capture id and direction, clear that pending bit, go to CHECK.
- CHECK: compute the target.
  - x=0 moving left, x=MAP_WIDTH-1 moving right, y=0 moving up, or y=MAP_HEIGHT-1 moving down -> code 1, no wrap, go to DECIDE.
  - Else if the target equals the current position of any other entity -> code 2, go to DECIDE.
  - Else register ram_addr = ty*MAP_WIDTH + tx (zero-extended to ADDR_W) and go to WAIT.
- WAIT: hold for exactly RAM_LAT cycles, then go to DECIDE.
- DECIDE: if a read was made, sample ram_data into done_tile and set code 3 if ram_data > PASS_MAX, else code 0. Register the done_* outputs and, if code is 0, update that entity's position on the same edge. Return to IDLE.
- done_valid is high for exactly one cycle, the cycle after DECIDE. IDLE may grant in that same cycle, giving back-to-back service.
- Latency from the cycle move_req is high to done_valid high: 4+RAM_LAT cycles for a read path (5 with RAM_LAT=1); 4 cycles for a code 1 or 2 rejection.
- Positions change only on code 0 and only for the granted entity. Collision is checked against positions at CHECK time, so two entities can never occupy one cell.
- ram_addr holds its last value outside WAIT.

Test Plan:
- Reset, then entity 0 at (0,0) requests right; RAM at addr 1 = 5 -> done_valid 5 cycles later, id 0, code 0, tile 5, pos_x[0]=1, ram_addr=1.
- Entity 0 at (0,0) requests up -> code 1, pos unchanged, no change on ram_addr, done 4 cycles after request.
- Entities 1 and 2 at (3,3) and (4,3); entity 1 requests right -> code 2, both positions unchanged.
- Target tile id 20 with PASS_MAX=15 -> code 3, done_tile=20, position unchanged.
- move_req=4'b1111 in one cycle -> four done pulses in id order 0,1,2,3. Then entity 0 re-requests while entity 3 is serviced -> next grant is 0 via wrap-around.
- Assert sys_rst during WAIT -> no done pulse, positions back to INIT values, busy=0 the next cycle, and a new request completes normally.

Source files
------------

// File: rtl/entity_move_arbiter.sv
// Round-robin move arbiter for N_ENT entities: bounds, occupancy and tile-passability
// checks on each request, with ownership of every entity position.
//
// state  | meaning
// IDLE   | waiting for a pending request; grants round-robin from last_grant+1
// CHECK  | target computed; bounds and occupancy tested, RAM read issued if clear
// WAIT   | RAM_LAT cycles for the map tile read
// DECIDE | result registered onto done_*, position updated on a successful move
module entity_move_arbiter #(
    parameter int N_ENT      = 4,
    parameter int COORD_W    = 4,
    parameter int MAP_WIDTH  = 16,
    parameter int MAP_HEIGHT = 16,
    parameter int ADDR_W     = 19,
    parameter int TILE_W     = 16,
    parameter int RAM_LAT    = 1,
    parameter int PASS_MAX   = 15,
    parameter logic [N_ENT*COORD_W-1:0] INIT_X = '0,
    parameter logic [N_ENT*COORD_W-1:0] INIT_Y = '0,
    localparam int ID_W  = (N_ENT > 1) ? $clog2(N_ENT) : 1,
    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic [N_ENT-1:0]           move_req,
    input  logic [2*N_ENT-1:0]         move_dir,
    output logic [N_ENT*COORD_W-1:0]   pos_x,
    output logic [N_ENT*COORD_W-1:0]   pos_y,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic [TILE_W-1:0]          ram_data,
    output logic                       done_valid,
    output logic [ID_W-1:0]            done_id,
    output logic [1:0]                 done_code,
    output logic [TILE_W-1:0]          done_tile,
    output logic                       busy
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_DECIDE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [COORD_W-1:0]   r_pos_x [N_ENT];
    logic [COORD_W-1:0]   r_pos_y [N_ENT];
    logic [N_ENT-1:0]     r_pend;
    logic [1:0]           r_dir [N_ENT];
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_id;
    logic [1:0]           r_gdir;
    logic [COORD_W-1:0]   r_tx;
    logic [COORD_W-1:0]   r_ty;
    logic                 r_read;
    logic [1:0]           r_code;
    logic [LAT_W-1:0]     r_wait;

    logic                 w_found;
    logic [ID_W-1:0]      w_gnt_id;
    logic                 w_grant;
    logic [N_ENT-1:0]     w_clr;
    logic [COORD_W-1:0]   w_cur_x;
    logic [COORD_W-1:0]   w_cur_y;
    logic [COORD_W-1:0]   w_tx;
    logic [COORD_W-1:0]   w_ty;
    logic                 w_oob;
    logic                 w_coll;
    logic [ADDR_W-1:0]    w_addr;
    logic [1:0]           w_dec_code;

    // Two passes give round-robin order: indices above last_grant first, then wrap.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (!w_found && r_pend[i] && (ID_W'(i) > r_last)) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < N_ENT; i++) begin
            if (!w_found && r_pend[i]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_ENT; i++) begin
            w_clr[i] = w_grant && (w_gnt_id == ID_W'(i));
        end
    end

    always_comb begin
        w_cur_x = r_pos_x[r_id];
        w_cur_y = r_pos_y[r_id];
        w_tx    = w_cur_x;
        w_ty    = w_cur_y;
        w_oob   = 1'b0;
        case (r_gdir)
            2'd0: begin
                w_oob = (w_cur_y == '0);
                w_ty  = w_cur_y - COORD_W'(1);
            end
            2'd1: begin
                w_oob = (w_cur_y == COORD_W'(MAP_HEIGHT - 1));
                w_ty  = w_cur_y + COORD_W'(1);
            end
            2'd2: begin
                w_oob = (w_cur_x == '0);
                w_tx  = w_cur_x - COORD_W'(1);
            end
            default: begin
                w_oob = (w_cur_x == COORD_W'(MAP_WIDTH - 1));
                w_tx  = w_cur_x + COORD_W'(1);
            end
        endcase
    end

    always_comb begin
        w_coll = 1'b0;
        for (int j = 0; j < N_ENT; j++) begin
            if ((ID_W'(j) != r_id) && (r_pos_x[j] == w_tx) && (r_pos_y[j] == w_ty)) begin
                w_coll = 1'b1;
            end
        end
    end

    assign w_addr     = ADDR_W'(w_ty) * ADDR_W'(MAP_WIDTH) + ADDR_W'(w_tx);
    assign w_dec_code = r_read ? ((ram_data > TILE_W'(PASS_MAX)) ? 2'd3 : 2'd0) : r_code;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK:  w_state_nxt = (w_oob || w_coll) ? S_DECIDE : S_WAIT;
            S_WAIT:   w_state_nxt = (r_wait == '0) ? S_DECIDE : S_WAIT;
            S_DECIDE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_pos_x[i] <= INIT_X[i*COORD_W +: COORD_W];
                r_pos_y[i] <= INIT_Y[i*COORD_W +: COORD_W];
                r_dir[i]   <= 2'd0;
            end
            r_pend     <= '0;
            r_last     <= ID_W'(N_ENT - 1);
            r_id       <= '0;
            r_gdir     <= 2'd0;
            r_tx       <= '0;
            r_ty       <= '0;
            r_read     <= 1'b0;
            r_code     <= 2'd0;
            r_wait     <= '0;
            ram_addr   <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_code  <= 2'd0;
            done_tile  <= '0;
        end else begin
            done_valid <= 1'b0;
            // A new request on the granting edge survives because it is ORed after the clear.
            r_pend <= (r_pend & ~w_clr) | move_req;
            for (int i = 0; i < N_ENT; i++) begin
                if (move_req[i]) begin
                    r_dir[i] <= move_dir[2*i +: 2];
                end
            end
            if (w_grant) begin
                r_id   <= w_gnt_id;
                r_last <= w_gnt_id;
                r_gdir <= r_dir[w_gnt_id];
            end
            if (r_state == S_CHECK) begin
                r_tx   <= w_tx;
                r_ty   <= w_ty;
                r_code <= w_oob ? 2'd1 : 2'd2;
                r_wait <= LAT_W'(RAM_LAT - 1);
                r_read <= !w_oob && !w_coll;
                if (!w_oob && !w_coll) begin
                    ram_addr <= w_addr;
                end
            end
            if ((r_state == S_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - LAT_W'(1);
            end
            if (r_state == S_DECIDE) begin
                done_valid <= 1'b1;
                done_id    <= r_id;
                done_code  <= w_dec_code;
                done_tile  <= r_read ? ram_data : '0;
                if (w_dec_code == 2'd0) begin
                    r_pos_x[r_id] <= r_tx;
                    r_pos_y[r_id] <= r_ty;
                end
            end
        end
    end

    for (genvar g = 0; g < N_ENT; g++) begin : g_pos
        assign pos_x[g*COORD_W +: COORD_W] = r_pos_x[g];
        assign pos_y[g*COORD_W +: COORD_W] = r_pos_y[g];
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_entity_move_arbiter.sv
// Directed bench for entity_move_arbiter with a one-cycle-latency map RAM model.
module tb_entity_move_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  move_req;
    logic [7:0]  move_dir;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [18:0] ram_addr;
    logic [15:0] ram_data;
    logic        done_valid;
    logic [1:0]  done_id;
    logic [1:0]  done_code;
    logic [15:0] done_tile;
    logic        busy;

    logic [15:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[ram_addr[7:0]];

    entity_move_arbiter #(
        .N_ENT(4), .COORD_W(4), .MAP_WIDTH(16), .MAP_HEIGHT(16),
        .ADDR_W(19), .TILE_W(16), .RAM_LAT(1), .PASS_MAX(15),
        .INIT_X(16'h8430), .INIT_Y(16'h8330)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .move_req(move_req), .move_dir(move_dir),
        .pos_x(pos_x), .pos_y(pos_y), .ram_addr(ram_addr), .ram_data(ram_data),
        .done_valid(done_valid), .done_id(done_id), .done_code(done_code),
        .done_tile(done_tile), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse a request for one cycle and count falling edges until done_valid (-1 if none).
    task automatic req_wait(input logic [3:0] mask, input logic [7:0] dirs, output int lat);
        @(negedge clk);
        move_req = mask;
        move_dir = dirs;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            move_req = '0;
            if (done_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int cnt;
        logic [1:0] ids [5];
        logic [1:0] codes [5];
        int times [5];

        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        mem[1]   = 16'd5;
        mem[68]  = 16'd20;
        mem[135] = 16'd15;

        sys_rst  = 1'b1;
        move_req = '0;
        move_dir = '0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_pos_x", pos_x, 16'h8430);
        chk("rst_pos_y", pos_y, 16'h8330);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_done_code", done_code, 0);
        chk("rst_done_tile", done_tile, 0);

        // entity 0 (0,0) right -> (1,0), tile 5
        req_wait(4'b0001, 8'h03, lat);
        chk("mv_lat", lat, 5);
        chk("mv_id", done_id, 0);
        chk("mv_code", done_code, 0);
        chk("mv_tile", done_tile, 5);
        chk("mv_pos_x", pos_x, 16'h8431);
        chk("mv_ram_addr", ram_addr, 1);
        @(negedge clk);
        chk("mv_pulse_width", done_valid, 0);

        // entity 0 (1,0) up -> top edge
        req_wait(4'b0001, 8'h00, lat);
        chk("oob_lat", lat, 4);
        chk("oob_code", done_code, 1);
        chk("oob_tile", done_tile, 0);
        chk("oob_pos_x", pos_x, 16'h8431);
        chk("oob_pos_y", pos_y, 16'h8330);
        chk("oob_ram_addr", ram_addr, 1);

        // entity 1 (3,3) right -> entity 2 at (4,3)
        req_wait(4'b0010, 8'h0C, lat);
        chk("coll_lat", lat, 4);
        chk("coll_id", done_id, 1);
        chk("coll_code", done_code, 2);
        chk("coll_pos_x", pos_x, 16'h8431);
        chk("coll_pos_y", pos_y, 16'h8330);

        // entity 2 (4,3) down -> (4,4) addr 68 tile 20 blocked
        req_wait(4'b0100, 8'h10, lat);
        chk("blk_lat", lat, 5);
        chk("blk_id", done_id, 2);
        chk("blk_code", done_code, 3);
        chk("blk_tile", done_tile, 20);
        chk("blk_ram_addr", ram_addr, 68);
        chk("blk_pos_y", pos_y, 16'h8330);

        // entity 3 (8,8) left -> (7,8) addr 135 tile 15 exactly passable
        req_wait(4'b1000, 8'h80, lat);
        chk("pmax_lat", lat, 5);
        chk("pmax_code", done_code, 0);
        chk("pmax_tile", done_tile, 15);
        chk("pmax_pos_x", pos_x, 16'h7431);

        // all four at once, entity 0 re-requests while entity 3 is granted
        @(negedge clk);
        move_req = 4'b1111;
        move_dir = 8'h31;
        n = 0;
        for (int c = 1; c <= 60 && n < 5; c++) begin
            @(negedge clk);
            move_req = '0;
            if (done_valid) begin
                ids[n]   = done_id;
                codes[n] = done_code;
                times[n] = c;
                n++;
                if (n == 3) begin
                    move_req = 4'b0001;
                    move_dir = 8'h03;
                end
            end
        end
        chk("burst_count", n, 5);
        if (n == 5) begin
            chk("burst_id0", ids[0], 0);
            chk("burst_id1", ids[1], 1);
            chk("burst_id2", ids[2], 2);
            chk("burst_id3", ids[3], 3);
            chk("burst_id4_wrap", ids[4], 0);
            chk("burst_first_lat", times[0], 5);
            for (int i = 0; i < 5; i++) chk("burst_code", codes[i], 0);
            for (int i = 1; i < 5; i++) chk("burst_gap", times[i] - times[i-1], 4);
        end
        chk("burst_pos_x", pos_x, 16'h7532);
        chk("burst_pos_y", pos_y, 16'h7321);

        // entity 1 (3,2) down -> (3,3) addr 51; reset lands while in WAIT
        @(negedge clk);
        move_req = 4'b0010;
        move_dir = 8'h04;
        @(negedge clk);
        move_req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_ram_addr", ram_addr, 51);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pos_x", pos_x, 16'h8430);
        chk("mid_rst_pos_y", pos_y, 16'h8330);
        chk("mid_rst_ram_addr", ram_addr, 0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_valid) cnt++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", cnt, 0);

        req_wait(4'b0001, 8'h03, lat);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_code", done_code, 0);
        chk("post_rst_tile", done_tile, 5);
        chk("post_rst_pos_x", pos_x, 16'h8431);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
